i2c_slave_regs: RTL and testbench
=================================

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 Parameter DEV_ADDR, default 7'h3C, SHALL set the 7-bit target address this block responds to.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of input synchronizer flops on SCL and SDA; minimum 2.
REQ-003 Port clk, input, 1: system clock, 50 MHz; all logic SHALL be on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port scl, input, 1: I2C clock from the bus master, up to 400 kHz.
REQ-006 Port sda, inout, 1: I2C data; the block SHALL drive only 1'b0 or 1'bz.
REQ-007 Port reg_addr, output, 8: current register pointer.
REQ-008 Port reg_wdata, output, 8: received data byte.
REQ-009 Port reg_we, output, 1: one-cycle write strobe; reg_addr and reg_wdata are valid in the same cycle.
REQ-010 Port reg_re, output, 1: one-cycle read request for reg_addr.
REQ-011 Port reg_rdata, input, 8: read data, valid one clk after reg_re.
REQ-012 Port busy, output, 1: high from an addressed START until STOP or a NACK/mismatch abort.

Function
REQ-013 SCL and SDA SHALL pass through SYNC_STAGES flops plus one history flop; edges SHALL be detected on the synchronized signals.
REQ-014 START: synchronized SDA falls while SCL is high; it SHALL enter ADDR from any state (repeated START included) and clear the bit counter.
REQ-015 STOP: synchronized SDA rises while SCL is high; it SHALL enter IDLE from any state and release SDA in the same cycle.
REQ-016 Data bits SHALL be sampled on the SCL rising-edge detect cycle, MSB first.
REQ-017 SDA drive changes SHALL occur only in the cycle after an SCL falling-edge detect.
REQ-018 FSM states: IDLE, ADDR, ADDR_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-019 ADDR: after 8 bits, if addr[7:1]==DEV_ADDR go to ADDR_ACK (drive 0 for the 9th clock), else go to IGNORE with SDA released; general call (0x00) SHALL be ignored.
REQ-020 ADDR_ACK with R/W=0 SHALL go to WADDR; with R/W=1 it SHALL pulse reg_re in the ACK rising-edge cycle and go to RDATA.
REQ-021 WADDR: the 8 bits SHALL load reg_addr, then ACK and go to WDATA.
REQ-022 WDATA: on the 8th rising edge, reg_wdata SHALL update; reg_we SHALL pulse one clk later; then ACK; then reg_addr SHALL increment at the ACK-phase falling edge.
REQ-023 RDATA: reg_rdata SHALL be latched into the shift register; bits SHALL be driven (0 is drive low, 1 is z), MSB first, each from an SCL falling edge; SDA SHALL be released for the 9th clock.
REQ-024 RDATA_ACK: master ACK (0) SHALL increment reg_addr, pulse reg_re, and return to RDATA; master NACK (1) SHALL go to IGNORE.
REQ-025 reg_addr SHALL wrap 8'hFF to 8'h00 on increment.
REQ-026 IGNORE SHALL drive nothing and wait for START or STOP.
REQ-027 START and STOP detection SHALL take priority over bit sampling in the same cycle.
REQ-028 reg_addr SHALL persist across transactions, so a write of only the word address followed by a repeated START read SHALL read from that address.

Reset
REQ-029 While rst_n is low: state IDLE, sda released (z), reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, bit counter=0, and synchronizers preset to 1.
REQ-030 Reset asserted mid-transaction SHALL release SDA immediately (asynchronously), and the block SHALL wait for a fresh START.

Structure
REQ-031 The FSM state encoding and the I2C_ACK/I2C_NACK constants SHALL live in shared package i2c_pkg, which is also usable by i2c_drv.
REQ-032 One sub-module, i2c_line_sync, SHALL contain the synchronizers plus scl_rise/scl_fall/start/stop detection.
REQ-033 Target size is 150-300 RTL lines; no register storage SHALL be inside this block.

Verification
REQ-034 Write to 0x78 (0x3C+W), 0x10, 0xA5, 0x5A, STOP -> three ACKs + data ACKs; reg_we at addr 0x10 with data 0xA5, then at 0x11 with 0x5A; busy drops at STOP.
REQ-035 Write to 0x7A (wrong address) -> no ACK (SDA stays high on the 9th clock), no reg_we/reg_re, and busy stays 0.
REQ-036 Write 0x78, 0x20, then repeated START, 0x79, read 2 bytes with ACK then NACK; memory model 0x20=0x3C, 0x21=0xC3 -> SDA bytes 0x3C, 0xC3; two reg_re pulses; IGNORE until STOP.
REQ-037 Write 0x78, 0xFF, 0x11, 0x22 -> reg_we at 0xFF=0x11, then at 0x00=0x22 (wrap).
REQ-038 Assert rst_n low during the 5th data bit of a read -> SDA is z within the same clk; a following correct write transaction completes normally.
REQ-039 STOP issued after 4 bits of a WDATA byte -> IDLE, no reg_we, and SDA released.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK line levels, byte/bit-counter widths.
package i2c_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 4;

  localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = BIT_CNT_W'(8);

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WADDR,
    WADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with one history flop each; decodes SCL edges and START/STOP.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_hist;
  logic                   sda_hist;

  // Idle bus level is high, so everything presets to 1 to avoid false edges out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_hist <= scl_sync[SYNC_STAGES-1];
      sda_hist <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise_c = scl_s & ~scl_hist;
  assign scl_fall_c = ~scl_s & scl_hist;
  assign start_c    = scl_s & scl_hist & sda_hist & ~sda_s;
  assign stop_c     = scl_s & scl_hist & ~sda_hist & sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target bridging bus transactions to an external register file via a
// word-address pointer with auto-increment on multi-byte writes and reads.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h3C,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl,
  inout  wire               sda,
  output logic [BYTE_W-1:0] reg_addr,
  output logic [BYTE_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [BYTE_W-1:0] reg_rdata,
  output logic              busy
);

  logic scl_s, sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl        (scl),
    .sda        (sda),
    .scl_s      (scl_s),
    .sda_s      (sda_s),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  i2c_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic [BYTE_W-1:0]    reg_addr_d, reg_wdata_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 rw_q, rw_d;
  logic                 we_pend_q, we_pend_d;
  logic                 rd_load_q;
  logic                 reg_we_d, reg_re_d, busy_d;
  logic                 addr_hit;

  // Open-drain: only ever pull low; the flop's async reset releases the line immediately.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign addr_hit = (shift_q[7:1] == DEV_ADDR) && (shift_q[7:1] != 7'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sda_oe_q  <= 1'b0;
      rw_q      <= 1'b0;
      we_pend_q <= 1'b0;
      rd_load_q <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sda_oe_q  <= sda_oe_d;
      rw_q      <= rw_d;
      we_pend_q <= we_pend_d;
      rd_load_q <= reg_re;
      reg_addr  <= reg_addr_d;
      reg_wdata <= reg_wdata_d;
      reg_we    <= reg_we_d;
      reg_re    <= reg_re_d;
      busy      <= busy_d;
    end
  end

  // Each *_ACK state spans exactly the 9th SCL clock: entered and left on SCL falls.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sda_oe_d    = sda_oe_q;
    rw_d        = rw_q;
    we_pend_d   = 1'b0;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    reg_we_d    = we_pend_q;
    reg_re_d    = 1'b0;
    busy_d      = busy;

    if (stop_c) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_c) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      // Read data arrives one clk after the read strobe.
      if (rd_load_q) shift_d = reg_rdata;

      unique case (state_q)
        ADDR, WADDR, WDATA: begin
          if (scl_rise_c && bit_cnt_q != BITS_PER_BYTE) begin
            shift_d   = {shift_q[BYTE_W-2:0], sda_s};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (state_q == WDATA && bit_cnt_q == BITS_PER_BYTE - BIT_CNT_W'(1)) begin
              reg_wdata_d = {shift_q[BYTE_W-2:0], sda_s};
              we_pend_d   = 1'b1;
            end
          end else if (scl_fall_c && bit_cnt_q == BITS_PER_BYTE) begin
            sda_oe_d = 1'b1;
            unique case (state_q)
              ADDR: begin
                if (addr_hit) begin
                  state_d = ADDR_ACK;
                  rw_d    = shift_q[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d  = IGNORE;
                  sda_oe_d = 1'b0;
                  busy_d   = 1'b0;
                end
              end
              WADDR: begin
                state_d    = WADDR_ACK;
                reg_addr_d = shift_q;
              end
              default: state_d = WDATA_ACK;
            endcase
          end
        end

        ADDR_ACK: begin
          if (scl_rise_c && rw_q) begin
            reg_re_d = 1'b1;
          end else if (scl_fall_c) begin
            bit_cnt_d = '0;
            state_d   = rw_q ? RDATA : WADDR;
            sda_oe_d  = rw_q ? ~shift_q[BYTE_W-1] : 1'b0;
          end
        end

        WADDR_ACK, WDATA_ACK: begin
          if (scl_fall_c) begin
            state_d   = WDATA;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            if (state_q == WDATA_ACK) reg_addr_d = reg_addr + BYTE_W'(1);
          end
        end

        RDATA: begin
          if (scl_rise_c && bit_cnt_q != BITS_PER_BYTE) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end else if (scl_fall_c) begin
            if (bit_cnt_q == BITS_PER_BYTE) begin
              state_d  = RDATA_ACK;
              sda_oe_d = 1'b0;
            end else begin
              shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
              sda_oe_d = ~shift_q[BYTE_W-2];
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise_c) begin
            if (sda_s == I2C_NACK) begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end else begin
              reg_addr_d = reg_addr + BYTE_W'(1);
              reg_re_d   = 1'b1;
            end
          end else if (scl_fall_c) begin
            state_d   = RDATA;
            bit_cnt_d = '0;
            sda_oe_d  = ~shift_q[BYTE_W-1];
          end
        end

        IDLE, IGNORE: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, register-file read model,
// and queue-based scoreboard for write strobes, read strobes and bus bytes/ACKs.
module tb_i2c_slave_regs;

  localparam int unsigned Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_low = 1'b0;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_we, reg_re, busy;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #10 clk = ~clk;

  i2c_slave_regs #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda       (sda),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  logic [7:0] mem [256];
  always @(posedge clk) if (reg_re) reg_rdata <= mem[reg_addr];

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_we[$];
  logic [7:0]  exp_re[$];
  logic [7:0]  exp_bus[$];
  logic [7:0]  obs_bus[$];
  string       bus_name[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [15:0] act);
    n_checks++;
    $display("FAIL %s: got unexpected event %h, expected none", name, act);
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or the master observes a byte.
  always @(negedge clk) begin
    logic [7:0] o;
    if (reg_we) begin
      if (exp_we.size() == 0) unexpected("reg_we", {reg_addr, reg_wdata});
      else check("reg_we addr/data", {reg_addr, reg_wdata}, exp_we.pop_front());
    end
    if (reg_re) begin
      if (exp_re.size() == 0) unexpected("reg_re", {8'h00, reg_addr});
      else check("reg_re addr", {8'h00, reg_addr}, {8'h00, exp_re.pop_front()});
    end
    if (obs_bus.size() != 0) begin
      o = obs_bus.pop_front();
      if (exp_bus.size() == 0) unexpected("bus", {8'h00, o});
      else check(bus_name.pop_front(), {8'h00, o}, {8'h00, exp_bus.pop_front()});
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic write_bit(input logic b);
    sda_low = ~b; wait_q();
    scl = 1'b1;   wait_q(); wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_low = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    b = sda;        wait_q();
    scl = 1'b0;     wait_q();
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    sda_low = 1'b1; wait_q();
    scl = 1'b0;     wait_q();
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; wait_q();
    scl = 1'b1;     wait_q();
    sda_low = 1'b0; wait_q(); wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic a;
    exp_bus.push_back({7'd0, exp_ack});
    bus_name.push_back(nm);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(a);
    obs_bus.push_back({7'd0, a});
  endtask

  task automatic recv_byte(input logic [7:0] exp, input logic master_ack, input string nm);
    logic [7:0] d;
    logic       b;
    exp_bus.push_back(exp);
    bus_name.push_back(nm);
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    obs_bus.push_back(d);
    write_bit(master_ack);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1);
  end

  initial begin
    logic [3:0] nib;
    logic       b;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'hC3;
    mem[8'h30] = 8'hF0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst reg_addr", {8'h00, reg_addr}, 16'h0000);
    check("rst reg_wdata", {8'h00, reg_wdata}, 16'h0000);
    check("rst reg_we", {15'd0, reg_we}, 16'h0000);
    check("rst reg_re", {15'd0, reg_re}, 16'h0000);
    check("rst busy", {15'd0, busy}, 16'h0000);
    check("rst sda released", {15'd0, sda}, 16'h0001);
    rst_n = 1'b1;
    wait_q();

    // Two-byte write with pointer auto-increment
    i2c_start();
    send_byte(8'h78, 1'b0, "wr1 addr ack");
    check("wr1 busy after addr", {15'd0, busy}, 16'h0001);
    send_byte(8'h10, 1'b0, "wr1 waddr ack");
    exp_we.push_back(16'h10A5);
    send_byte(8'hA5, 1'b0, "wr1 data0 ack");
    exp_we.push_back(16'h115A);
    send_byte(8'h5A, 1'b0, "wr1 data1 ack");
    i2c_stop();
    check("wr1 busy after stop", {15'd0, busy}, 16'h0000);
    check("wr1 reg_addr after", {8'h00, reg_addr}, 16'h0012);

    // Wrong address: no ACK, no strobes, never busy
    i2c_start();
    send_byte(8'h7A, 1'b1, "wrong addr nack");
    check("wrong addr busy", {15'd0, busy}, 16'h0000);
    send_byte(8'h10, 1'b1, "wrong addr byte2 nack");
    i2c_stop();

    // Set pointer, repeated START, read two bytes (ACK then NACK)
    i2c_start();
    send_byte(8'h78, 1'b0, "rd addr w ack");
    send_byte(8'h20, 1'b0, "rd waddr ack");
    i2c_start();
    exp_re.push_back(8'h20);
    send_byte(8'h79, 1'b0, "rd addr r ack");
    exp_re.push_back(8'h21);
    recv_byte(8'h3C, 1'b0, "rd byte0");
    recv_byte(8'hC3, 1'b1, "rd byte1");
    check("rd busy after nack", {15'd0, busy}, 16'h0000);
    check("rd sda released in ignore", {15'd0, sda}, 16'h0001);
    i2c_stop();

    // Pointer wrap FF -> 00
    i2c_start();
    send_byte(8'h78, 1'b0, "wrap addr ack");
    send_byte(8'hFF, 1'b0, "wrap waddr ack");
    exp_we.push_back(16'hFF11);
    send_byte(8'h11, 1'b0, "wrap data0 ack");
    exp_we.push_back(16'h0022);
    send_byte(8'h22, 1'b0, "wrap data1 ack");
    i2c_stop();
    check("wrap reg_addr after", {8'h00, reg_addr}, 16'h0001);

    // STOP after 4 data bits: abort without a write
    i2c_start();
    send_byte(8'h78, 1'b0, "abort addr ack");
    send_byte(8'h40, 1'b0, "abort waddr ack");
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    check("abort busy", {15'd0, busy}, 16'h0000);
    check("abort reg_addr", {8'h00, reg_addr}, 16'h0040);
    check("abort reg_wdata kept", {8'h00, reg_wdata}, 16'h0022);
    check("abort sda released", {15'd0, sda}, 16'h0001);

    // Reset during the 5th bit of a read byte
    i2c_start();
    send_byte(8'h78, 1'b0, "rst addr w ack");
    send_byte(8'h30, 1'b0, "rst waddr ack");
    i2c_start();
    exp_re.push_back(8'h30);
    send_byte(8'h79, 1'b0, "rst addr r ack");
    exp_bus.push_back(8'h0F);
    bus_name.push_back("rst first nibble");
    for (int i = 3; i >= 0; i--) begin
      read_bit(b);
      nib[i] = b;
    end
    obs_bus.push_back({4'h0, nib});
    sda_low = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    check("rst bit5 driven low", {15'd0, sda}, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("rst sda released async", {15'd0, sda}, 16'h0001);
    check("rst busy cleared", {15'd0, busy}, 16'h0000);
    wait_q();
    scl = 1'b0; wait_q();
    rst_n = 1'b1; wait_q();
    i2c_stop();
    i2c_start();
    send_byte(8'h78, 1'b0, "post rst addr ack");
    send_byte(8'h50, 1'b0, "post rst waddr ack");
    exp_we.push_back(16'h5077);
    send_byte(8'h77, 1'b0, "post rst data ack");
    i2c_stop();

    // Anything still expected was never seen
    repeat (50) @(negedge clk);
    while (exp_we.size() != 0) begin
      n_checks++;
      $display("FAIL reg_we missing: got none, expected %h", exp_we.pop_front());
    end
    while (exp_re.size() != 0) begin
      n_checks++;
      $display("FAIL reg_re missing: got none, expected %h", exp_re.pop_front());
    end
    while (exp_bus.size() != 0) begin
      n_checks++;
      $display("FAIL %s missing: got none, expected %h", bus_name.pop_front(), exp_bus.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
